ram_sync_param: RTL and testbench
=================================

Name: ram_sync_param

Overview:
Parametrised single-port synchronous RAM. It is the clocked, generalised successor to the fixed 1024x8 cs/wr/rd RAM.
- Adds configurable width and depth, byte-lane write enables and an optional output register.
- Adds a registered read-valid handshake and a post-reset clear sweep.
- Sits beside register files and buffers as the team's general-purpose on-chip memory.

Parameters:
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width in bits; must be a multiple of 8
OUT_REG, 0, 1 adds one output pipeline register (read latency 2 instead of 1)
CLEAR_ON_RESET, 1, 1 runs the clear sweep after reset; 0 skips straight to READY
CLEAR_VALUE, 0, word value written by the clear sweep

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cs  input  1  chip select; request ignored when 0
wr  input  1  write request (qualified by cs)
rd  input  1  read request (qualified by cs)
addr  input  ADDR_WIDTH  word address
data_in  input  DATA_WIDTH  write data
be  input  DATA_WIDTH/8  byte enables; bit i gates data_in[8i+7:8i]
data_out  output  DATA_WIDTH  read data, meaningful when rd_valid=1
rd_valid  output  1  one-cycle pulse marking valid data_out
busy  output  1  high during the clear sweep
rejected  output  1  one-cycle pulse: request arrived while busy

Behaviour:
Reset values (asynchronous on rst=1):
- data_out=0, rd_valid=0, rejected=0.
- busy=CLEAR_ON_RESET; clear counter=0; FSM=INIT if CLEAR_ON_RESET, else READY.
- Memory contents are not reset directly.

FSM states:
- INIT: each cycle, write CLEAR_VALUE to address cnt, then cnt++.
- INIT exits to READY on the cycle it writes address DEPTH-1. The sweep is exactly DEPTH cycles.
- busy=1 for the whole of INIT and drops in the first READY cycle.
- READY: normal operation; stays there until the next rst.

Requests in INIT:
- Any cs&(wr|rd) is dropped: no memory change, no rd_valid.
- rejected pulses high in the following cycle.

Write in READY (cs=1, wr=1):
- Bytes with be[i]=1 update at the clock edge.
- be=0 makes the write a no-op.

Read in READY (cs=1, rd=1):
- addr is sampled at the clock edge.
- OUT_REG=0: data_out and rd_valid update at that edge (latency 1).
- OUT_REG=1: they update one edge later (latency 2).
- Back-to-back reads are allowed every cycle; rd_valid follows the rd pattern, delayed by the latency.

Simultaneous wr & rd, same address: read-first.
- data_out returns the pre-write word; the write still happens.

Holding behaviour:
- When no read completes, data_out holds its last value and rd_valid=0.

Reset mid-operation (rst asserted in any state):
- In-flight reads are discarded: pipeline cleared, rd_valid=0.
- The sweep restarts from address 0 after rst deasserts.

Address wrap:
- Cannot go out of range, since addr spans exactly DEPTH.
- The sweep counter is ADDR_WIDTH+1 bits or compares against DEPTH-1; it never wraps silently into READY early.

Decomposition:
- Shared package ram_pkg holds:
  - state enum: ST_INIT, ST_READY
  - function bytes_of(DATA_WIDTH) = DATA_WIDTH/8
  - localparam check flagging DATA_WIDTH%8 != 0
- One sub-module, ram_sync_core. It contains:
  - the memory array
  - the byte-enabled synchronous write port
  - the read-first synchronous read port
- The top level holds the FSM, clear counter, request gating, optional output register, rd_valid/rejected logic, and the mux that gives the sweep write port priority.

Test Plan:
- Default params, release rst, idle: busy stays 1 for exactly 1024 cycles, then 0. A read of addr 5 then returns 0 with rd_valid one cycle after the request.
- Default params, after init: write data_in=(2k)%256, be=1, for k=0..1023. Read 20 pseudo-random addresses (seed 20): each returns (2*addr)%256, latency 1.
- DATA_WIDTH=16, OUT_REG=1: write 0xFFFF to addr 3. Then write 0xABCD with be=2'b01, then read addr 3: data_out=0xFFCD, rd_valid exactly 2 cycles after the read.
- Same-cycle wr=1, rd=1 to addr 7 (old 0x11, new 0x22): data_out=0x11. A following read returns 0x22.
- Request during INIT: write 0x55 to addr 0 at cycle 10 of the sweep. rejected pulses once; after init, addr 0 reads CLEAR_VALUE.
- Assert rst mid-stream (read issued, OUT_REG=1): rd_valid never pulses for that read. busy re-asserts, and the sweep runs a full DEPTH cycles again.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and elaboration helpers for the parametrised synchronous RAM.
// The top level and its storage core both import this package.
package ram_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int bytes_of(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

    // True only when the word splits cleanly into whole byte lanes.
    function automatic bit width_is_bytes(input int data_width);
        return (data_width > 0) && ((data_width % BYTE_BITS) == 0);
    endfunction

endpackage

// File: rtl/ram_sync_core.sv
// Storage array with a byte-enabled synchronous write port and a read-first
// synchronous read port that share a single address.
module ram_sync_core
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [bytes_of(DATA_WIDTH)-1:0] we,
    input  logic                            re,
    output logic [DATA_WIDTH-1:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = bytes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[addr][BYTE_BITS*i +: BYTE_BITS] <= wdata[BYTE_BITS*i +: BYTE_BITS];
            end
        end
    end

    // The non-blocking write above lands after this sample, so a read and a
    // write to the same word in one cycle returns the pre-write contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM: clear sweep after reset, request
// gating while sweeping, read-valid pulse and an optional output register.
module ram_sync_param
    import ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 10,
    parameter int                    DATA_WIDTH     = 8,
    parameter bit                    OUT_REG        = 1'b0,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cs,
    input  logic                            wr,
    input  logic                            rd,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [bytes_of(DATA_WIDTH)-1:0] be,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            rd_valid,
    output logic                            busy,
    output logic                            rejected
);

    localparam int                    NB        = bytes_of(DATA_WIDTH);
    localparam bit                    WIDTH_OK  = width_is_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    if (!WIDTH_OK) begin : g_width_check
        $error("ram_sync_param: DATA_WIDTH must be a non-zero multiple of 8");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  sweeping;
    logic                  req;
    logic                  rd_go;
    logic                  wr_go;
    logic                  rd_valid_q1;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;
    logic [NB-1:0]         core_we;

    assign sweeping = (state == ST_INIT);
    assign busy     = sweeping;
    assign req      = cs & (wr | rd);
    assign rd_go    = ~sweeping & cs & rd;
    assign wr_go    = ~sweeping & cs & wr;

    // The sweep leaves INIT on the same edge that writes the last address,
    // so it occupies exactly DEPTH cycles and the counter never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
            cnt   <= '0;
        end else if (state == ST_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ADDR) begin
                state <= ST_READY;
            end
        end
    end

    always_comb begin
        core_addr  = addr;
        core_wdata = data_in;
        core_we    = wr_go ? be : '0;
        if (sweeping) begin
            core_addr  = cnt;
            core_wdata = CLEAR_VALUE;
            core_we    = '1;
        end
    end

    ram_sync_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .addr  (core_addr),
        .wdata (core_wdata),
        .we    (core_we),
        .re    (rd_go),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rejected    <= 1'b0;
            rd_valid_q1 <= 1'b0;
        end else begin
            rejected    <= sweeping & req;
            rd_valid_q1 <= rd_go;
        end
    end

    // Optional extra stage; it only captures when a read actually completed
    // so data_out keeps holding the last returned word.
    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        logic                  valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_valid_q1;
                if (rd_valid_q1) begin
                    out_q <= core_rdata;
                end
            end
        end

        assign data_out = out_q;
        assign rd_valid = valid_q;
    end else begin : g_no_out_reg
        assign data_out = core_rdata;
        assign rd_valid = rd_valid_q1;
    end

endmodule

// File: tb/tb_ram_sync_param.sv
// Bench for ram_sync_param: a default 1024x8 instance and a 1024x16 instance
// with output register, both driven by the same requests and a memory model.
module tb_ram_sync_param;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [15:0] CLR_B = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, wr, rd;
    logic [9:0]  addr;
    logic [15:0] data_in;
    logic [1:0]  be;

    logic [7:0]  data_out_a;
    logic        rd_valid_a, busy_a, rejected_a;
    logic [15:0] data_out_b;
    logic        rd_valid_b, busy_b, rejected_b;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model: word arrays plus what each output should show now.
    logic [7:0]  mem_a [DEPTH];
    logic [15:0] mem_b [DEPTH];
    int          sweep_edges;
    logic        ea_v, eb_v, eb_pend_v, exp_rej;
    logic [7:0]  ea_d;
    logic [15:0] eb_d, eb_pend_d;

    always #5 clk = ~clk;

    ram_sync_param dut_a (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .data_in  (data_in[7:0]),
        .be       (be[0:0]),
        .data_out (data_out_a),
        .rd_valid (rd_valid_a),
        .busy     (busy_a),
        .rejected (rejected_a)
    );

    ram_sync_param #(
        .DATA_WIDTH  (16),
        .OUT_REG     (1'b1),
        .CLEAR_VALUE (CLR_B)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .data_in  (data_in),
        .be       (be),
        .data_out (data_out_b),
        .rd_valid (rd_valid_b),
        .busy     (busy_b),
        .rejected (rejected_b)
    );

    task automatic model_reset();
        sweep_edges = 0;
        ea_v = 1'b0; ea_d = 8'h00;
        eb_v = 1'b0; eb_d = 16'h0000;
        eb_pend_v = 1'b0; eb_pend_d = 16'h0000;
        exp_rej = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_edge();
        bit          ready;
        bit          rd_ok;
        logic [7:0]  old_a;
        logic [15:0] old_b;
        if (rst) begin
            model_reset();
            return;
        end
        ready = (sweep_edges >= DEPTH);
        rd_ok = ready && cs && rd;
        old_a = mem_a[addr];
        old_b = mem_b[addr];
        eb_v = eb_pend_v;
        if (eb_pend_v) eb_d = eb_pend_d;
        eb_pend_v = rd_ok;
        if (rd_ok) eb_pend_d = old_b;
        ea_v = rd_ok;
        if (rd_ok) ea_d = old_a;
        exp_rej = !ready && cs && (wr || rd);
        if (ready && cs && wr) begin
            if (be[0]) mem_a[addr] = data_in[7:0];
            for (int i = 0; i < 2; i++)
                if (be[i]) mem_b[addr][8*i +: 8] = data_in[8*i +: 8];
        end
        if (!ready) begin
            sweep_edges++;
            if (sweep_edges == DEPTH) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_a[j] = 8'h00;
                    mem_b[j] = CLR_B;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    // Ticks until busy drops (bounded), optionally injecting one write at edge inject_at.
    task automatic run_sweep(input int inject_at, output int n, output int rej_a,
                             output int rej_b, output int vld);
        n = 0; rej_a = 0; rej_b = 0; vld = 0;
        while (busy_a === 1'b1 && n < 2*DEPTH) begin
            if (n == inject_at - 1) begin
                cs = 1'b1; wr = 1'b1; addr = 10'd0; data_in = 16'h0055; be = 2'b11;
            end
            tick();
            n++;
            idle();
            if (rejected_a === 1'b1) rej_a++;
            if (rejected_b === 1'b1) rej_b++;
            if (rd_valid_a === 1'b1 || rd_valid_b === 1'b1) vld++;
        end
    endtask

    task automatic test_reset();
        int n, ra, rb, v;
        idle(); addr = '0; data_in = '0; be = '0;
        rst = 1'b1; model_reset(); #1;
        n_vec++;
        if (data_out_a !== 8'h00 || rd_valid_a !== 1'b0 || rejected_a !== 1'b0 || busy_a !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL reset_a got dout=%h vld=%b rej=%b busy=%b want 00/0/0/1",
                     data_out_a, rd_valid_a, rejected_a, busy_a);
        end
        n_vec++;
        if (data_out_b !== 16'h0000 || rd_valid_b !== 1'b0 || rejected_b !== 1'b0 || busy_b !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL reset_b got dout=%h vld=%b rej=%b busy=%b want 0000/0/0/1",
                     data_out_b, rd_valid_b, rejected_b, busy_b);
        end
        tick(); tick();
        rst = 1'b0;
        run_sweep(0, n, ra, rb, v);
        n_vec++;
        if (n !== DEPTH || busy_b !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL sweep_len got %0d cycles busy_b=%b want %0d cycles busy_b=0", n, busy_b, DEPTH);
        end
        cs = 1'b1; rd = 1'b1; addr = 10'd5;
        tick(); idle();
        n_vec++;
        if (rd_valid_a !== 1'b1 || data_out_a !== 8'h00) begin
            n_miss++;
            $display("[TB] FAIL read5_a got vld=%b dout=%h want 1/00", rd_valid_a, data_out_a);
        end
        n_vec++;
        if (rd_valid_b !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL read5_b_early got vld=%b want 0", rd_valid_b);
        end
        tick();
        n_vec++;
        if (rd_valid_b !== 1'b1 || data_out_b !== CLR_B || rd_valid_a !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL read5_b got vld=%b dout=%h vld_a=%b want 1/%h/0",
                     rd_valid_b, data_out_b, rd_valid_a, CLR_B);
        end
    endtask

    task automatic test_fill_and_read();
        logic [9:0] ra;
        for (int k = 0; k < DEPTH; k++) begin
            cs = 1'b1; wr = 1'b1; addr = 10'(k);
            data_in = {8'(k*5 + 1), 8'(2*k)};
            be = {1'($urandom_range(0, 1)), 1'b1};
            tick();
        end
        idle();
        void'($urandom(20));
        for (int i = 0; i < 20; i++) begin
            ra = 10'($urandom_range(0, DEPTH-1));
            cs = 1'b1; rd = 1'b1; addr = ra;
            tick(); idle();
            n_vec++;
            if (rd_valid_a !== 1'b1 || data_out_a !== 8'(2*ra) || data_out_a !== ea_d) begin
                n_miss++;
                $display("[TB] FAIL fill_read_a addr=%0d got vld=%b dout=%h want 1/%h",
                         ra, rd_valid_a, data_out_a, 8'(2*ra));
            end
            tick();
            n_vec++;
            if (rd_valid_b !== 1'b1 || data_out_b !== eb_d || rd_valid_a !== 1'b0) begin
                n_miss++;
                $display("[TB] FAIL fill_read_b addr=%0d got vld=%b dout=%h want 1/%h",
                         ra, rd_valid_b, data_out_b, eb_d);
            end
        end
    endtask

    task automatic test_byte_enable();
        cs = 1'b1; wr = 1'b1; addr = 10'd3; data_in = 16'hFFFF; be = 2'b11; tick();
        data_in = 16'hABCD; be = 2'b01; tick();
        data_in = 16'h1234; be = 2'b00; tick();
        wr = 1'b0; rd = 1'b1; tick(); idle();
        n_vec++;
        if (rd_valid_a !== 1'b1 || data_out_a !== 8'hCD || rd_valid_b !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL be_a got vld=%b dout=%h vld_b=%b want 1/cd/0", rd_valid_a, data_out_a, rd_valid_b);
        end
        tick();
        n_vec++;
        if (rd_valid_b !== 1'b1 || data_out_b !== 16'hFFCD) begin
            n_miss++;
            $display("[TB] FAIL be_b got vld=%b dout=%h want 1/ffcd", rd_valid_b, data_out_b);
        end
        tick();
        n_vec++;
        if (rd_valid_b !== 1'b0 || data_out_b !== 16'hFFCD || data_out_a !== 8'hCD) begin
            n_miss++;
            $display("[TB] FAIL hold got vld_b=%b dout_b=%h dout_a=%h want 0/ffcd/cd", rd_valid_b, data_out_b, data_out_a);
        end
    endtask

    task automatic test_read_first();
        cs = 1'b1; wr = 1'b1; addr = 10'd7; data_in = 16'h1111; be = 2'b11; tick();
        rd = 1'b1; data_in = 16'h2222; tick();
        wr = 1'b0;
        n_vec++;
        if (rd_valid_a !== 1'b1 || data_out_a !== 8'h11) begin
            n_miss++;
            $display("[TB] FAIL rdfirst_a got vld=%b dout=%h want 1/11", rd_valid_a, data_out_a);
        end
        tick(); idle();
        n_vec++;
        if (rd_valid_b !== 1'b1 || data_out_b !== 16'h1111 || data_out_a !== 8'h22) begin
            n_miss++;
            $display("[TB] FAIL rdfirst_b got vld=%b dout_b=%h dout_a=%h want 1/1111/22", rd_valid_b, data_out_b, data_out_a);
        end
        tick();
        n_vec++;
        if (rd_valid_b !== 1'b1 || data_out_b !== 16'h2222) begin
            n_miss++;
            $display("[TB] FAIL after_write_b got vld=%b dout=%h want 1/2222", rd_valid_b, data_out_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            if (i < 12) begin
                cs = 1'b1; wr = 1'b0; rd = 1'b1;
            end else begin
                cs = ($urandom_range(0, 3) != 0);
                wr = 1'($urandom_range(0, 1));
                rd = 1'($urandom_range(0, 1));
            end
            addr = 10'($urandom_range(0, 15));
            data_in = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            tick();
            n_vec++;
            if (rd_valid_a !== ea_v || data_out_a !== ea_d) begin
                n_miss++;
                $display("[TB] FAIL b2b_a cyc=%0d got vld=%b dout=%h want %b/%h", i, rd_valid_a, data_out_a, ea_v, ea_d);
            end
            n_vec++;
            if (rd_valid_b !== eb_v || data_out_b !== eb_d || rejected_a !== 1'b0) begin
                n_miss++;
                $display("[TB] FAIL b2b_b cyc=%0d got vld=%b dout=%h rej=%b want %b/%h/0",
                         i, rd_valid_b, data_out_b, rejected_a, eb_v, eb_d);
            end
        end
        idle(); tick(); tick();
    endtask

    task automatic test_init_reject();
        int n, ra, rb, v;
        rst = 1'b1; model_reset(); #1;
        tick();
        rst = 1'b0;
        run_sweep(10, n, ra, rb, v);
        n_vec++;
        if (ra !== 1 || rb !== 1 || v !== 0) begin
            n_miss++;
            $display("[TB] FAIL init_reject got rej_a=%0d rej_b=%0d valids=%0d want 1/1/0", ra, rb, v);
        end
        n_vec++;
        if (n !== DEPTH) begin
            n_miss++;
            $display("[TB] FAIL init_reject_len got %0d want %0d", n, DEPTH);
        end
        cs = 1'b1; rd = 1'b1; addr = 10'd0; tick(); idle(); tick();
        n_vec++;
        if (data_out_a !== 8'h00 || data_out_b !== CLR_B || rd_valid_b !== 1'b1 || data_out_b !== eb_d) begin
            n_miss++;
            $display("[TB] FAIL addr0_cleared got a=%h b=%h vld_b=%b want 00/%h/1", data_out_a, data_out_b, rd_valid_b, CLR_B);
        end
    endtask

    task automatic test_reset_midstream();
        int n, ra, rb, v;
        cs = 1'b1; rd = 1'b1; addr = 10'd3; tick(); idle();
        rst = 1'b1; model_reset(); #1;
        n_vec++;
        if (rd_valid_b !== 1'b0 || rd_valid_a !== 1'b0 || busy_a !== 1'b1 || busy_b !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL midrst got vld_a=%b vld_b=%b busy=%b/%b want 0/0/1/1", rd_valid_a, rd_valid_b, busy_a, busy_b);
        end
        tick();
        n_vec++;
        if (rd_valid_b !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL midrst_inflight got vld_b=%b want 0", rd_valid_b);
        end
        rst = 1'b0;
        run_sweep(0, n, ra, rb, v);
        n_vec++;
        if (n !== DEPTH || v !== 0 || ra !== 0) begin
            n_miss++;
            $display("[TB] FAIL midrst_sweep got len=%0d valids=%0d rej=%0d want %0d/0/0", n, v, ra, DEPTH);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle(); addr = '0; data_in = '0; be = '0;
        test_reset();
        test_fill_and_read();
        test_byte_enable();
        test_read_first();
        test_back_to_back();
        test_init_reject();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
